hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 16-bit 5-stage core. Generates EX-stage forwarding selects, load-use bubbles, redirect flushes and data-memory wait stalls.
//  Drives every stall_*/flush_* pipeline-register control and alu_src1/alu_src2 of the EX stage. Contains an FSM with a memory-wait watchdog counter.
// PARAMETERS
//  REG_WIDTH    4   register-index width
//  MEM_TIMEOUT  16  max MEM_WAIT cycles before forced release (>=2)
//  CNT_WIDTH    16  perf/watchdog counter width
// PORTS
//  clk             in   1          clock, all state on posedge
//  rst             in   1          asynchronous, active-high reset
//  rs1D_i,rs2D_i   in   REG_WIDTH  source regs of instruction in ID
//  rs1E_i,rs2E_i   in   REG_WIDTH  source regs of instruction in EX
//  WriteRegE_i     in   REG_WIDTH  dest reg in EX
//  RegWriteE_i     in   1          EX writes RF
//  MemReadE_i      in   1          EX is a load
//  WriteRegM_i     in   REG_WIDTH  dest reg in MEM
//  RegWriteM_i     in   1          MEM writes RF
//  MemReadM_i      in   1          MEM load
//  MemWriteM_i     in   1          MEM store
//  mem_ready_i     in   1          data memory completes access this cycle
//  BranchTakenM_i  in   1          taken branch resolved in MEM
//  jumpM_i         in   1          jump in MEM
//  WriteRegW_i     in   REG_WIDTH  dest reg in WB
//  RegWriteW_i     in   1          WB writes RF
//  alu_src1_o      out  2          0=RF, 1=WBResultM, 2=ResultW
//  alu_src2_o      out  2          same encoding, operand 2
//  stall_PC_o, stall_IF_ID_o, stall_ID_EX_o, stall_EX_MEM_o   out 1 each  hold register
//  flush_IF_ID_o, flush_ID_EX_o, flush_EX_MEM_o               out 1 each  bubble register
//  mem_err_o       out  1          sticky: watchdog expired
//  stall_cnt_o     out  CNT_WIDTH  stall cycles (perf option)
//  flush_cnt_o     out  CNT_WIDTH  redirect events (perf option)
// BEHAVIOUR
//  Forwarding (combinational): srcN=1 if RegWriteM_i && WriteRegM_i==rsNE_i; else 2 if RegWriteW_i && WriteRegW_i==rsNE_i; else 0. M beats W.
//  FSM states RUN, MEM_WAIT; reset -> RUN, watchdog=0, mem_err_o=0, perf counts=0. All stall/flush outputs are combinational, =0 under reset.
//  RUN priority (highest first):
//   1 mem busy: (MemReadM_i|MemWriteM_i)&&!mem_ready_i -> assert all four stalls, no flush; next=MEM_WAIT, watchdog=1.
//   2 redirect: BranchTakenM_i|jumpM_i -> flush_IF_ID, flush_ID_EX, flush_EX_MEM for 1 cycle; no stall (PC loads target). Overrides load-use.
//   3 load-use: MemReadE_i&&RegWriteE_i&&WriteRegE_i in {rs1D_i,rs2D_i} -> stall_PC, stall_IF_ID, flush_ID_EX for exactly 1 cycle.
//   4 otherwise all 0.
//  MEM_WAIT: mem_ready_i=0 and watchdog<MEM_TIMEOUT -> all four stalls, watchdog++.
//   mem_ready_i=1 -> release (no stall); apply RUN rules 2/3 this cycle; next=RUN, watchdog=0.
//   watchdog==MEM_TIMEOUT w/o ready -> release as above, set mem_err_o (held until rst).
//  Forwarding selects stay valid while stalled (EX inputs held upstream).
//  rst asserted mid-MEM_WAIT: immediate return to RUN, all outputs 0 asynchronously.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt_o += 1 every cycle any stall_* is high; flush_cnt_o += 1 per redirect cycle; both saturate at all-ones.
//  Undefined: ports remain, tied to 0, no counter flops.
// STRUCTURE
//  hazard_pkg: state enum (RUN, MEM_WAIT); FWD_RF=2'd0, FWD_M=2'd1, FWD_W=2'd2.
//  Sub-module hazard_fwd_sel (pure comparator/priority mux), instantiated once per ALU operand. FSM, watchdog and counters in the top.
// TESTING
//  Fwd: M wr r3, W wr r3, rs1E=3 -> alu_src1_o=1; clear RegWriteM -> 2; rs2E=4 -> alu_src2_o=0.
//  Load-use: MemReadE, WriteRegE=5, rs2D=5 -> 1 cycle stall_PC/IF_ID + flush_ID_EX; next cycle all 0.
//  Mem wait: MemReadM, mem_ready low 3 cycles -> 4 stalls high 3 cycles; ready cycle stalls 0, state RUN.
//  Timeout MEM_TIMEOUT=4, ready never high -> release after 4 MEM_WAIT cycles, mem_err_o=1 sticky.
//  Redirect+load-use same cycle: BranchTakenM=1 -> three flushes, stall_PC=0; perf build flush_cnt_o=1.
//  rst pulse during MEM_WAIT -> outputs 0 same cycle, state RUN, mem_err_o=0, counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazState_t;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX-stage operand forwarding select for one ALU source; the MEM-stage result wins over WB.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_WIDTH = 4
) (
    input  logic [REG_WIDTH-1:0] rsE,
    input  logic [REG_WIDTH-1:0] writeRegM,
    input  logic                 regWriteM,
    input  logic [REG_WIDTH-1:0] writeRegW,
    input  logic                 regWriteW,
    output logic [1:0]           fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (regWriteM && (writeRegM == rsE)) begin
            fwdSel = FWD_M;
        end else if (regWriteW && (writeRegW == rsE)) begin
            fwdSel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: forwarding selects, load-use bubbles, redirect flushes and memory-wait stalls.
// Define HAZ_PERF_CNT_EN to build the saturating stall/redirect performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_WIDTH   = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_WIDTH-1:0] rs1D_i,
    input  logic [REG_WIDTH-1:0] rs2D_i,
    input  logic [REG_WIDTH-1:0] rs1E_i,
    input  logic [REG_WIDTH-1:0] rs2E_i,
    input  logic [REG_WIDTH-1:0] WriteRegE_i,
    input  logic                 RegWriteE_i,
    input  logic                 MemReadE_i,
    input  logic [REG_WIDTH-1:0] WriteRegM_i,
    input  logic                 RegWriteM_i,
    input  logic                 MemReadM_i,
    input  logic                 MemWriteM_i,
    input  logic                 mem_ready_i,
    input  logic                 BranchTakenM_i,
    input  logic                 jumpM_i,
    input  logic [REG_WIDTH-1:0] WriteRegW_i,
    input  logic                 RegWriteW_i,
    output logic [1:0]           alu_src1_o,
    output logic [1:0]           alu_src2_o,
    output logic                 stall_PC_o,
    output logic                 stall_IF_ID_o,
    output logic                 stall_ID_EX_o,
    output logic                 stall_EX_MEM_o,
    output logic                 flush_IF_ID_o,
    output logic                 flush_ID_EX_o,
    output logic                 flush_EX_MEM_o,
    output logic                 mem_err_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int                  WD_WIDTH = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_WIDTH-1:0] WD_MAX   = WD_WIDTH'(MEM_TIMEOUT);

    hazState_t           state;
    logic [WD_WIDTH-1:0] watchdog;
    logic                memErr;
    logic [1:0]          fwdSel1;
    logic [1:0]          fwdSel2;
    logic                memBusy;
    logic                redirect;
    logic                loadUse;
    logic                holdAll;

    hazard_fwd_sel #(.REG_WIDTH(REG_WIDTH)) fwdSrc1 (
        .rsE       (rs1E_i),
        .writeRegM (WriteRegM_i),
        .regWriteM (RegWriteM_i),
        .writeRegW (WriteRegW_i),
        .regWriteW (RegWriteW_i),
        .fwdSel    (fwdSel1)
    );

    hazard_fwd_sel #(.REG_WIDTH(REG_WIDTH)) fwdSrc2 (
        .rsE       (rs2E_i),
        .writeRegM (WriteRegM_i),
        .regWriteM (RegWriteM_i),
        .writeRegW (WriteRegW_i),
        .regWriteW (RegWriteW_i),
        .fwdSel    (fwdSel2)
    );

    assign alu_src1_o = rst ? FWD_RF : fwdSel1;
    assign alu_src2_o = rst ? FWD_RF : fwdSel2;
    assign mem_err_o  = memErr;

    assign memBusy  = (MemReadM_i || MemWriteM_i) && !mem_ready_i;
    assign redirect = BranchTakenM_i || jumpM_i;
    assign loadUse  = MemReadE_i && RegWriteE_i &&
                      ((WriteRegE_i == rs1D_i) || (WriteRegE_i == rs2D_i));

    // In MEM_WAIT the access is held until ready or the watchdog runs out; the release cycle behaves like RUN.
    assign holdAll = (state == RUN) ? memBusy
                                    : (!mem_ready_i && (watchdog < WD_MAX));

    always_comb begin
        stall_PC_o     = 1'b0;
        stall_IF_ID_o  = 1'b0;
        stall_ID_EX_o  = 1'b0;
        stall_EX_MEM_o = 1'b0;
        flush_IF_ID_o  = 1'b0;
        flush_ID_EX_o  = 1'b0;
        flush_EX_MEM_o = 1'b0;
        if (!rst) begin
            if (holdAll) begin
                stall_PC_o     = 1'b1;
                stall_IF_ID_o  = 1'b1;
                stall_ID_EX_o  = 1'b1;
                stall_EX_MEM_o = 1'b1;
            end else if (redirect) begin
                flush_IF_ID_o  = 1'b1;
                flush_ID_EX_o  = 1'b1;
                flush_EX_MEM_o = 1'b1;
            end else if (loadUse) begin
                stall_PC_o     = 1'b1;
                stall_IF_ID_o  = 1'b1;
                flush_ID_EX_o  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            watchdog <= '0;
            memErr   <= 1'b0;
        end else if (state == RUN) begin
            if (memBusy) begin
                state    <= MEM_WAIT;
                watchdog <= WD_WIDTH'(1);
            end
        end else begin
            if (mem_ready_i) begin
                state    <= RUN;
                watchdog <= '0;
            end else if (watchdog < WD_MAX) begin
                watchdog <= watchdog + 1'b1;
            end else begin
                state    <= RUN;
                watchdog <= '0;
                memErr   <= 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stallCnt;
    logic [CNT_WIDTH-1:0] flushCnt;
    logic                 anyStall;
    logic                 redirectFlush;

    assign anyStall      = stall_PC_o || stall_IF_ID_o || stall_ID_EX_o || stall_EX_MEM_o;
    // Only a redirect flushes IF/ID, so it marks redirect cycles.
    assign redirectFlush = flush_IF_ID_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (anyStall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if (redirectFlush && (flushCnt != '1)) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stallCnt;
    assign flush_cnt_o = flushCnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios then randomized traffic against a rule-level model.
module tb_hazard_ctrl;

    localparam int RW = 4;
    localparam int MT = 4;
    localparam int CW = 6;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          rst;
        logic [RW-1:0] rs1D, rs2D, rs1E, rs2E;
        logic [RW-1:0] writeRegE;
        logic          regWriteE, memReadE;
        logic [RW-1:0] writeRegM;
        logic          regWriteM, memReadM, memWriteM, memReady, branchM, jumpM;
        logic [RW-1:0] writeRegW;
        logic          regWriteW;
    } stim_t;

    typedef struct packed {
        logic [1:0]    src1, src2;
        logic [3:0]    stalls;
        logic [2:0]    flushes;
        logic          err;
        logic [CW-1:0] stallCnt, flushCnt;
    } exp_t;

    logic          clk, rst;
    logic [RW-1:0] rs1D, rs2D, rs1E, rs2E, writeRegE, writeRegM, writeRegW;
    logic          regWriteE, memReadE, regWriteM, memReadM, memWriteM, memReady;
    logic          branchM, jumpM, regWriteW;
    logic [1:0]    aluSrc1, aluSrc2;
    logic          stallPC, stallIFID, stallIDEX, stallEXMEM;
    logic          flushIFID, flushIDEX, flushEXMEM;
    logic          memErr;
    logic [CW-1:0] stallCnt, flushCnt;

    int   nChecks = 0;
    int   nErrors = 0;
    int   cycle   = 0;
    exp_t expQ[$];

    // Model state: how many stall cycles the current memory access has consumed.
    bit mWaiting;
    int mStallCycles;
    bit mErr;
    int mStallCnt, mFlushCnt;

    hazard_ctrl #(.REG_WIDTH(RW), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1D_i         (rs1D),
        .rs2D_i         (rs2D),
        .rs1E_i         (rs1E),
        .rs2E_i         (rs2E),
        .WriteRegE_i    (writeRegE),
        .RegWriteE_i    (regWriteE),
        .MemReadE_i     (memReadE),
        .WriteRegM_i    (writeRegM),
        .RegWriteM_i    (regWriteM),
        .MemReadM_i     (memReadM),
        .MemWriteM_i    (memWriteM),
        .mem_ready_i    (memReady),
        .BranchTakenM_i (branchM),
        .jumpM_i        (jumpM),
        .WriteRegW_i    (writeRegW),
        .RegWriteW_i    (regWriteW),
        .alu_src1_o     (aluSrc1),
        .alu_src2_o     (aluSrc2),
        .stall_PC_o     (stallPC),
        .stall_IF_ID_o  (stallIFID),
        .stall_ID_EX_o  (stallIDEX),
        .stall_EX_MEM_o (stallEXMEM),
        .flush_IF_ID_o  (flushIFID),
        .flush_ID_EX_o  (flushIDEX),
        .flush_EX_MEM_o (flushEXMEM),
        .mem_err_o      (memErr),
        .stall_cnt_o    (stallCnt),
        .flush_cnt_o    (flushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] fwdExp(input logic [RW-1:0] rs, input stim_t s);
        if (s.regWriteM && s.writeRegM == rs) return 2'd1;
        if (s.regWriteW && s.writeRegW == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    // Drive one cycle of inputs, predict the response and advance the model across the coming edge.
    task automatic applyStimulus(input stim_t s);
        exp_t e;
        bit   pending, hold, timeout, redir, loadUse;
        @(posedge clk);
        #1;
        rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        writeRegE = s.writeRegE; regWriteE = s.regWriteE; memReadE = s.memReadE;
        writeRegM = s.writeRegM; regWriteM = s.regWriteM; memReadM = s.memReadM;
        memWriteM = s.memWriteM; memReady = s.memReady; branchM = s.branchM;
        jumpM = s.jumpM; writeRegW = s.writeRegW; regWriteW = s.regWriteW;
        e = '0;
        if (s.rst) begin
            mWaiting = 0; mStallCycles = 0; mErr = 0; mStallCnt = 0; mFlushCnt = 0;
        end else begin
            e.src1 = fwdExp(s.rs1E, s);
            e.src2 = fwdExp(s.rs2E, s);
            pending = mWaiting || s.memReadM || s.memWriteM;
            hold    = pending && !s.memReady && (mStallCycles < MT);
            timeout = mWaiting && !s.memReady && (mStallCycles >= MT);
            redir   = s.branchM || s.jumpM;
            loadUse = s.memReadE && s.regWriteE &&
                      (s.writeRegE == s.rs1D || s.writeRegE == s.rs2D);
            if (hold) e.stalls = 4'b1111;
            else if (redir) e.flushes = 3'b111;
            else if (loadUse) begin
                e.stalls  = 4'b1100;
                e.flushes = 3'b010;
            end
            e.err = mErr;
`ifdef HAZ_PERF_CNT_EN
            e.stallCnt = CW'(mStallCnt);
            e.flushCnt = CW'(mFlushCnt);
            if (e.stalls != 0 && mStallCnt < CNT_MAX) mStallCnt++;
            if (!hold && redir && mFlushCnt < CNT_MAX) mFlushCnt++;
`endif
            if (hold) begin
                mWaiting = 1;
                mStallCycles++;
            end else begin
                if (timeout) mErr = 1;
                mWaiting = 0;
                mStallCycles = 0;
            end
        end
        expQ.push_back(e);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        nChecks++;
        if (act != req) begin
            nErrors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("alu_src1", int'(aluSrc1), int'(e.src1));
        cmp("alu_src2", int'(aluSrc2), int'(e.src2));
        cmp("stalls", int'({stallPC, stallIFID, stallIDEX, stallEXMEM}), int'(e.stalls));
        cmp("flushes", int'({flushIFID, flushIDEX, flushEXMEM}), int'(e.flushes));
        cmp("mem_err", int'(memErr), int'(e.err));
        cmp("stall_cnt", int'(stallCnt), int'(e.stallCnt));
        cmp("flush_cnt", int'(flushCnt), int'(e.flushCnt));
    endtask

    // Monitor: every cycle presents a full output vector, compared at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        stim_t s;
        int    drain;
        rst = 1'b1;
        {rs1D, rs2D, rs1E, rs2E, writeRegE, writeRegM, writeRegW} = '0;
        {regWriteE, memReadE, regWriteM, memReadM, memWriteM, memReady} = '0;
        {branchM, jumpM, regWriteW} = '0;

        s = idle(); s.rst = 1'b1;
        repeat (3) applyStimulus(s);

        // Forwarding: M beats W, then W alone, operand 2 unmatched.
        s = idle();
        s.writeRegM = 3; s.regWriteM = 1; s.writeRegW = 3; s.regWriteW = 1;
        s.rs1E = 3; s.rs2E = 4;
        applyStimulus(s);
        s.regWriteM = 0;
        applyStimulus(s);

        // Load-use bubble for one cycle, then quiet.
        s = idle();
        s.memReadE = 1; s.regWriteE = 1; s.writeRegE = 5; s.rs2D = 5; s.rs1D = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Memory wait: three busy cycles then ready.
        s = idle(); s.memReadM = 1;
        repeat (3) applyStimulus(s);
        s.memReady = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // Watchdog expiry with ready never asserted; error must stick.
        s = idle(); s.memReadM = 1;
        repeat (MT + 1) applyStimulus(s);
        repeat (3) applyStimulus(idle());

        // Redirect coinciding with a load-use hazard.
        s = idle();
        s.branchM = 1; s.memReadE = 1; s.regWriteE = 1; s.writeRegE = 5; s.rs2D = 5;
        applyStimulus(s);
        applyStimulus(idle());

        // Reset pulse in the middle of a memory wait.
        s = idle(); s.memReadM = 1;
        repeat (2) applyStimulus(s);
        s.rst = 1;
        applyStimulus(s);
        applyStimulus(idle());
        applyStimulus(idle());

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst       = ($urandom_range(0, 199) == 0);
            s.rs1D      = RW'($urandom_range(0, 3));
            s.rs2D      = RW'($urandom_range(0, 3));
            s.rs1E      = RW'($urandom_range(0, 3));
            s.rs2E      = RW'($urandom_range(0, 3));
            s.writeRegE = RW'($urandom_range(0, 3));
            s.writeRegM = RW'($urandom_range(0, 3));
            s.writeRegW = RW'($urandom_range(0, 3));
            s.regWriteE = $urandom_range(0, 1);
            s.memReadE  = $urandom_range(0, 2) == 0;
            s.regWriteM = $urandom_range(0, 1);
            s.regWriteW = $urandom_range(0, 1);
            s.memReadM  = $urandom_range(0, 5) == 0;
            s.memWriteM = !s.memReadM && ($urandom_range(0, 7) == 0);
            s.memReady  = $urandom_range(0, 2) != 0;
            s.branchM   = $urandom_range(0, 6) == 0;
            s.jumpM     = $urandom_range(0, 9) == 0;
            applyStimulus(s);
        end

        drain = 0;
        while (expQ.size() > 0 && drain < 20) begin
            @(negedge clk);
            #1;
            drain++;
        end
        if (expQ.size() > 0) begin
            nChecks++;
            nErrors++;
            $display("[TB] FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
